// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and types for the fetch stage
// Purpose : data width, the NOP encoding driven to decode when idle, and the
//           fetch state encoding.
// Ports   : none (package)
package core_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_target.sv
// rtl/pc_target.sv - redirect target adder with JALR masking and alignment check
// Purpose : computes the redirect target of the EX instruction.
// Ports   : i_jalr_en  - select rs1-based (JALR) target
//           i_ex_pc    - PC of the EX instruction
//           i_imm      - sign-extended immediate
//           i_rs1_d    - JALR base register value
//           o_target   - redirect target (modulo 2^32)
//           o_misalign - target is not 4-byte aligned
module pc_target
   import core_pkg::*;
(
   input  logic            i_jalr_en,
   input  logic [XLEN-1:0] i_ex_pc,
   input  logic [XLEN-1:0] i_imm,
   input  logic [XLEN-1:0] i_rs1_d,
   output logic [XLEN-1:0] o_target,
   output logic            o_misalign
);

   logic [XLEN-1:0] w_sum;

   always_comb begin
      w_sum = i_jalr_en ? (i_rs1_d + i_imm) : (i_ex_pc + i_imm);
      // JALR clears bit 0, so only bit 1 can leave the target misaligned
      o_target   = i_jalr_en ? (w_sum & ~32'h1) : w_sum;
      o_misalign = o_target[1];
   end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and instruction fetch stage
// Purpose : holds the PC, requests instructions from imem, buffers one
//           fetched instruction for decode and applies EX-stage redirects.
// Ports   : i_clk, i_rst                  - clock, synchronous active-high reset
//           i_ex_valid, i_branch_en, i_b,
//           i_jal_en, i_jalr_en            - EX redirect qualifiers
//           i_ex_pc, i_imm, i_rs1_d        - EX target operands
//           o_imem_req, o_imem_addr,
//           i_imem_ack, i_imem_rdata       - instruction memory port
//           o_if_valid, i_if_ready,
//           o_if_instr, o_if_pc            - 1-entry buffer towards decode
//           o_flush, o_misalign            - single-cycle status pulses
module pc_fetch
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ex_valid,
   input  logic        i_branch_en,
   input  logic        i_b,
   input  logic        i_jal_en,
   input  logic        i_jalr_en,
   input  logic [31:0] i_ex_pc,
   input  logic [31:0] i_imm,
   input  logic [31:0] i_rs1_d,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_if_valid,
   input  logic        i_if_ready,
   output logic [31:0] o_if_instr,
   output logic [31:0] o_if_pc,
   output logic        o_flush,
   output logic        o_misalign
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_drain_addr;
   logic [31:0]  r_if_instr;
   logic [31:0]  r_if_pc;
   logic         r_if_valid;
   logic         r_flush;
   logic         r_misalign;

   logic [31:0]  w_target;
   logic         w_tgt_misalign;
   logic         w_redirect;
   logic         w_take;
   logic         w_req;
   logic         w_hs;

   pc_target u_pc_target (
      .i_jalr_en  (i_jalr_en),
      .i_ex_pc    (i_ex_pc),
      .i_imm      (i_imm),
      .i_rs1_d    (i_rs1_d),
      .o_target   (w_target),
      .o_misalign (w_tgt_misalign)
   );

   always_comb begin
      w_redirect = i_ex_valid & (i_jal_en | i_jalr_en | (i_branch_en & i_b));
      // A misaligned target only raises the status pulse; the PC is kept
      w_take     = w_redirect & ~w_tgt_misalign;
      w_hs       = r_if_valid & i_if_ready;
      // Once raised the request cannot drop before ack: raising it needs the
      // buffer empty or draining, and the buffer then stays empty until ack.
      w_req      = (r_state == REQ) ? (~r_if_valid | i_if_ready) : (r_state == DRAIN);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_drain_addr <= RESET_PC;
         r_if_instr   <= NOP_INSTR;
         r_if_pc      <= RESET_PC;
         r_if_valid   <= 1'b0;
         r_flush      <= 1'b0;
         r_misalign   <= 1'b0;
      end else begin
         r_flush    <= w_take;
         r_misalign <= w_redirect & w_tgt_misalign;

         if (w_hs) begin
            r_if_valid <= 1'b0;
         end
         if (w_take) begin
            r_pc       <= w_target;
            r_if_valid <= 1'b0;
         end

         case (r_state)
            IDLE: r_state <= REQ;
            REQ: begin
               if (w_take) begin
                  // Outstanding fetch must complete at its old address first
                  if (w_req & ~i_imem_ack) begin
                     r_state      <= DRAIN;
                     r_drain_addr <= r_pc;
                  end
               end else if (w_req & i_imem_ack) begin
                  r_if_instr <= i_imem_rdata;
                  r_if_pc    <= r_pc;
                  r_if_valid <= 1'b1;
                  r_pc       <= r_pc + 32'd4;
               end
            end
            DRAIN: begin
               if (i_imem_ack) begin
                  r_state <= REQ;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_imem_req  = w_req;
   assign o_imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;
   assign o_if_valid  = r_if_valid;
   assign o_if_instr  = r_if_valid ? r_if_instr : NOP_INSTR;
   assign o_if_pc     = r_if_pc;
   assign o_flush     = r_flush;
   assign o_misalign  = r_misalign;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, branch_en, b, jal_en, jalr_en;
   logic [31:0] ex_pc, imm, rs1_d;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;
   logic        flush, misalign;
   logic        ack_en;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Memory returns a tagged copy of the address so data identifies its source
   assign imem_rdata = {16'hA5A5, imem_addr[15:0]};
   assign imem_ack   = ack_en & imem_req;

   pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_ex_valid   (ex_valid),
      .i_branch_en  (branch_en),
      .i_b          (b),
      .i_jal_en     (jal_en),
      .i_jalr_en    (jalr_en),
      .i_ex_pc      (ex_pc),
      .i_imm        (imm),
      .i_rs1_d      (rs1_d),
      .o_imem_req   (imem_req),
      .o_imem_addr  (imem_addr),
      .i_imem_ack   (imem_ack),
      .i_imem_rdata (imem_rdata),
      .o_if_valid   (if_valid),
      .i_if_ready   (if_ready),
      .o_if_instr   (if_instr),
      .o_if_pc      (if_pc),
      .o_flush      (flush),
      .o_misalign   (misalign)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Advance one clock, then let combinational outputs settle before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_clear();
      ex_valid = 0; branch_en = 0; b = 0; jal_en = 0; jalr_en = 0;
      ex_pc = 0; imm = 0; rs1_d = 0;
   endtask

   initial begin
      rst = 1; ack_en = 0; if_ready = 0;
      ex_clear();

      // 1. Reset
      tick(); tick();
      #1;
      check("rst_req", {31'd0, imem_req}, 0);
      check("rst_valid", {31'd0, if_valid}, 0);
      check("rst_flush", {31'd0, flush}, 0);
      check("rst_misalign", {31'd0, misalign}, 0);
      check("rst_instr", if_instr, 32'h0000_0013);
      check("rst_if_pc", if_pc, 0);
      rst = 0;
      #1;
      check("idle_req", {31'd0, imem_req}, 0);
      tick();
      ack_en = 1; if_ready = 1;
      #1;
      check("first_req", {31'd0, imem_req}, 1);
      check("first_addr", imem_addr, 0);

      // 2. Streaming instructions 0 and 4
      for (int i = 0; i < 2; i++) begin
         tick();
         check("stream_valid", {31'd0, if_valid}, 1);
         check("stream_if_pc", if_pc, 32'(4 * i));
         check("stream_instr", if_instr, 32'hA5A5_0000 | 32'(4 * i));
         check("stream_addr", imem_addr, 32'(4 * i + 4));
      end

      // 3. Stall holding instr@4
      if_ready = 0;
      #1;
      check("stall_req_drop", {31'd0, imem_req}, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", {31'd0, if_valid}, 1);
         check("stall_if_pc", if_pc, 32'h4);
         check("stall_instr", if_instr, 32'hA5A5_0004);
         check("stall_req", {31'd0, imem_req}, 0);
         check("stall_addr", imem_addr, 32'h8);
      end
      if_ready = 1;
      #1;
      check("resume_req", {31'd0, imem_req}, 1);
      tick();
      check("resume_if_pc", if_pc, 32'h8);
      check("resume_addr", imem_addr, 32'hC);
      tick();
      check("stream_c_if_pc", if_pc, 32'hC);
      check("stream_c_addr", imem_addr, 32'h10);

      // 4. Taken branch back to 0x8, ack in the same cycle is discarded
      ex_valid = 1; branch_en = 1; b = 1; ex_pc = 32'h10; imm = 32'hFFFF_FFF8;
      tick();
      ex_clear();
      #1;
      check("br_flush", {31'd0, flush}, 1);
      check("br_valid", {31'd0, if_valid}, 0);
      check("br_instr_nop", if_instr, 32'h0000_0013);
      check("br_addr", imem_addr, 32'h8);
      tick();
      check("br_flush_end", {31'd0, flush}, 0);
      check("br_if_pc", if_pc, 32'h8);
      check("br_next_addr", imem_addr, 32'hC);
      ex_valid = 1; branch_en = 1; b = 0; ex_pc = 32'h10; imm = 32'hFFFF_FFF8;
      tick();
      ex_clear();
      check("nt_flush", {31'd0, flush}, 0);
      check("nt_if_pc", if_pc, 32'hC);
      check("nt_addr", imem_addr, 32'h10);

      // 5. JALR, misaligned JALR, JAL wrap-around
      ex_valid = 1; jalr_en = 1; rs1_d = 32'h201; imm = 0;
      tick();
      ex_clear();
      check("jalr_flush", {31'd0, flush}, 1);
      check("jalr_addr", imem_addr, 32'h200);
      tick();
      check("jalr_if_pc", if_pc, 32'h200);
      check("jalr_next_addr", imem_addr, 32'h204);
      ex_valid = 1; jalr_en = 1; rs1_d = 32'h101; imm = 32'h1;
      tick();
      ex_clear();
      check("mis_pulse", {31'd0, misalign}, 1);
      check("mis_no_flush", {31'd0, flush}, 0);
      check("mis_if_pc", if_pc, 32'h204);
      check("mis_addr", imem_addr, 32'h208);
      tick();
      check("mis_pulse_end", {31'd0, misalign}, 0);
      check("mis_addr2", imem_addr, 32'h20C);
      ex_valid = 1; jal_en = 1; ex_pc = 32'hFFFF_FFFC; imm = 32'h8;
      tick();
      ex_clear();
      check("wrap_flush", {31'd0, flush}, 1);
      check("wrap_addr", imem_addr, 32'h4);
      tick();
      check("wrap_if_pc", if_pc, 32'h4);
      check("wrap_next_addr", imem_addr, 32'h8);

      // 6. Redirect while a request is outstanding, then a second redirect
      ack_en = 0;
      tick();
      check("pend_req", {31'd0, imem_req}, 1);
      check("pend_addr", imem_addr, 32'h8);
      ex_valid = 1; jal_en = 1; ex_pc = 32'h40; imm = 32'h20;
      tick();
      ex_clear();
      check("drain_flush", {31'd0, flush}, 1);
      check("drain_req", {31'd0, imem_req}, 1);
      check("drain_addr", imem_addr, 32'h8);
      check("drain_valid", {31'd0, if_valid}, 0);
      tick();
      check("drain_flush_end", {31'd0, flush}, 0);
      check("drain_addr_hold", imem_addr, 32'h8);
      ex_valid = 1; jal_en = 1; ex_pc = 32'h100; imm = 32'h10;
      tick();
      ex_clear();
      check("drain2_flush", {31'd0, flush}, 1);
      check("drain2_addr", imem_addr, 32'h8);
      ack_en = 1;
      tick();
      check("drop_valid", {31'd0, if_valid}, 0);
      check("drop_req", {31'd0, imem_req}, 1);
      check("new_target_addr", imem_addr, 32'h110);
      tick();
      check("new_target_valid", {31'd0, if_valid}, 1);
      check("new_target_if_pc", if_pc, 32'h110);
      check("new_target_instr", if_instr, 32'hA5A5_0110);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
